// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encoding and score width, also used by the recorder.
package game_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      OVER  = 2'd3
   } state_t;

   localparam int unsigned SEC_W       = 10;
   localparam int unsigned MAX_SEC_DEF = 999;

   function automatic logic sec_at_max(input logic [SEC_W-1:0] s, input int unsigned max_sec);
      return s >= SEC_W'(max_sec);
   endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Prescaler dividing clk down to one wrap pulse per counted second while enabled.
module sec_tick_gen #(
   parameter int unsigned TICKS_PER_SEC = 25_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic wrap
);

   localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign wrap = en && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr || wrap) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/survival_timer.sv
// Game FSM and saturating seconds counter feeding the score display and end-of-game recorder.
module survival_timer
   import game_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = 25_000_000,
   parameter int unsigned MAX_SEC       = MAX_SEC_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             pause,
   input  logic             collide,
   output logic [SEC_W-1:0] sec,
   output logic             lose,
   output logic             game_over,
   output logic             running,
   output logic             tick
);

   state_t           state_q, state_d;
   logic [SEC_W-1:0] sec_q, sec_d;
   logic             lose_q, lose_d;
   logic             game_over_q, game_over_d;
   logic             running_q, running_d;
   logic             tick_q, tick_d;

   logic             cnt_en;
   logic             cnt_clr;
   logic             wrap;

   // Collide and pause both stall the prescaler so a coincident wrap never scores.
   assign cnt_en  = (state_q == RUN) && !pause && !collide;
   assign cnt_clr = ((state_q == IDLE) || (state_q == OVER)) && start;

   sec_tick_gen #(
      .TICKS_PER_SEC (TICKS_PER_SEC)
   ) u_sec_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (cnt_en),
      .clr  (cnt_clr),
      .wrap (wrap)
   );

   always_comb begin
      state_d = state_q;
      sec_d   = sec_q;
      lose_d  = 1'b0;
      tick_d  = 1'b0;
      unique case (state_q)
         IDLE, OVER: begin
            if (start) begin
               state_d = RUN;
               sec_d   = '0;
            end
         end
         RUN: begin
            if (collide) begin
               state_d = OVER;
               lose_d  = 1'b1;
            end else if (pause) begin
               state_d = PAUSE;
            end else if (wrap && !sec_at_max(sec_q, MAX_SEC)) begin
               sec_d  = sec_q + SEC_W'(1);
               tick_d = 1'b1;
            end
         end
         PAUSE: begin
            if (!pause) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      running_d   = (state_d == RUN);
      game_over_d = (state_d == OVER);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sec_q       <= '0;
         lose_q      <= 1'b0;
         game_over_q <= 1'b0;
         running_q   <= 1'b0;
         tick_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sec_q       <= sec_d;
         lose_q      <= lose_d;
         game_over_q <= game_over_d;
         running_q   <= running_d;
         tick_q      <= tick_d;
      end
   end

   assign sec       = sec_q;
   assign lose      = lose_q;
   assign game_over = game_over_q;
   assign running   = running_q;
   assign tick      = tick_q;

endmodule
